// File: rtl/aes_pkg.sv
// Shared types, constants and byte helpers for the AES-128 key schedule controller.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } ks_state_t;

    localparam int NUM_ROUNDS = 10;
    localparam int NK         = 4;
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Forward S-box; entry 0 is the leftmost byte of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four independent S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign sub[gi*8 +: 8] = SBOX[word[gi*8 +: 8]];
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key expansion (one round key per clock) with an indexed round-key read port.
// Optional build macro AES_KEY_ZEROIZE_EN adds a zeroize input that wipes all stored key material.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [0:127] key,
    output logic         busy,
    output logic         keys_valid,
    output logic         done,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic [0:127] rk_data
);
    import aes_pkg::*;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    ks_state_t    state_reg;
    logic [3:0]   round_reg;
    logic [7:0]   rcon_reg;
    logic [127:0] rk_mem [0:NUM_ROUNDS];
    logic [127:0] prev_key_reg;
    logic         busy_reg;
    logic         keys_valid_reg;
    logic         done_reg;
    logic         rk_valid_reg;
    logic [127:0] rk_data_reg;

    logic [127:0] key_word;
    logic [31:0]  p0, p1, p2, p3, sub, t, w0, w1, w2, w3;
    logic         zero_req;
    logic         accept;
    logic         rd_ok;

    assign key_word = key;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    // The previous round key is kept in its own register so the next-key path
    // starts at a flop instead of behind an 11-way array mux.
    assign {p0, p1, p2, p3} = prev_key_reg;

    aes_sub_word u_sub_word (
        .word ({p3[23:0], p3[31:24]}),
        .sub  (sub)
    );

    assign t  = sub ^ {rcon_reg, 24'h0};
    assign w0 = p0 ^ t;
    assign w1 = p1 ^ w0;
    assign w2 = p2 ^ w1;
    assign w3 = p3 ^ w2;

    assign key_ready = ~reset && (state_reg != ST_EXPAND);
    assign accept    = key_valid && (state_reg != ST_EXPAND);

    // An index being written on this edge is not yet readable, so reads
    // during EXPAND stop below round_reg and rk[0] is blocked while reloading.
    always_comb begin
        rd_ok = 1'b0;
        case (state_reg)
            ST_EXPAND: rd_ok = (rk_idx < round_reg);
            ST_DONE:   rd_ok = (rk_idx <= LAST) && !(accept && rk_idx == 4'd0);
            default:   rd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            round_reg      <= 4'd0;
            rcon_reg       <= RCON_INIT;
            prev_key_reg   <= '0;
            busy_reg       <= 1'b0;
            keys_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            rk_valid_reg   <= 1'b0;
            rk_data_reg    <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_mem[i] <= '0;
        end else if (zero_req) begin
            state_reg      <= ST_IDLE;
            round_reg      <= 4'd0;
            rcon_reg       <= RCON_INIT;
            prev_key_reg   <= '0;
            busy_reg       <= 1'b0;
            keys_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            rk_valid_reg   <= 1'b0;
            rk_data_reg    <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_mem[i] <= '0;
        end else begin
            done_reg     <= 1'b0;
            rk_valid_reg <= rk_req && rd_ok;
            rk_data_reg  <= (rk_req && rd_ok) ? rk_mem[rk_idx] : '0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (key_valid) begin
                        rk_mem[0]      <= key_word;
                        prev_key_reg   <= key_word;
                        round_reg      <= 4'd1;
                        rcon_reg       <= RCON_INIT;
                        busy_reg       <= 1'b1;
                        keys_valid_reg <= 1'b0;
                        state_reg      <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    rk_mem[round_reg] <= {w0, w1, w2, w3};
                    prev_key_reg      <= {w0, w1, w2, w3};
                    rcon_reg          <= xtime(rcon_reg);
                    if (round_reg == LAST) begin
                        state_reg      <= ST_DONE;
                        busy_reg       <= 1'b0;
                        done_reg       <= 1'b1;
                        keys_valid_reg <= 1'b1;
                    end else begin
                        round_reg <= round_reg + 4'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign keys_valid = keys_valid_reg;
    assign done       = done_reg;
    assign rk_valid   = rk_valid_reg;
    assign rk_data    = rk_data_reg;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench: independent GF(2^8) key-expansion model, read scoreboard, vector table.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         reset;
    logic         key_valid;
    logic         key_ready;
    logic [0:127] key;
    logic         busy;
    logic         keys_valid;
    logic         done;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [0:127] rk_data;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .reset      (reset),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done       (done),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_valid   (rk_valid),
        .rk_data    (rk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic         v;
        logic [127:0] d;
    } vec_t;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   tsbox [256];
    logic [127:0] sched [11];
    vec_t         sbq [$];
    vec_t         tbl [13];
    logic         pend;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from the multiplicative inverse and affine map, not from a table.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            if (a != 0)
                for (int x = 1; x < 256; x++)
                    if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            tsbox[a] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {tsbox[tmp[31:24]], tsbox[tmp[23:16]], tsbox[tmp[15:8]], tsbox[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Scoreboard: a request sampled on a rising edge is compared on the following falling edge.
    always @(posedge clk or posedge reset) begin
        if (reset) pend <= 1'b0;
        else       pend <= rk_req;
    end

    always @(negedge clk) begin
        if (pend) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: got a response with no expected entry");
            end else begin
                vec_t e;
                e = sbq.pop_front();
                $display("read idx=%0d valid=%0b data=%h", e.idx, rk_valid, rk_data);
                check($sformatf("rd_valid[%0d]", e.idx), 128'(rk_valid), 128'(e.v));
                check($sformatf("rd_data[%0d]", e.idx), rk_data, e.d);
            end
        end
    end

    task automatic rd(input logic [3:0] idx, input logic v, input logic [127:0] d);
        vec_t e;
        e = '{idx, v, d};
        rk_req = 1'b1;
        rk_idx = idx;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        rk_req = 1'b0;
    endtask

    task automatic start_key(input logic [127:0] k);
        int n = 0;
        key       = k;
        key_valid = 1'b1;
        while (!key_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!key_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL key_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        $display("key accepted %h", k);
        check("busy_after_accept", 128'(busy), 128'd1);
        check("keys_valid_after_accept", 128'(keys_valid), 128'd0);
    endtask

    task automatic wait_done(input logic [127:0] k, input bit hold, input bit otf);
        int  cyc = 0;
        bit  got = 0;
        if (hold) begin
            key       = ~k;
            key_valid = 1'b1;
        end
        while (cyc < 20 && !got) begin
            vec_t e;
            rk_req = 1'b0;
            if (otf && (cyc == 2 || cyc == 4)) begin
                e = (cyc == 2) ? '{4'd3, 1'b0, 128'h0} : '{4'd3, 1'b1, sched[3]};
                rk_req = 1'b1;
                rk_idx = 4'd3;
                sbq.push_back(e);
            end
            check("busy_expand", 128'(busy), 128'd1);
            if (hold) check("key_ready_expand", 128'(key_ready), 128'd0);
            @(posedge clk);
            cyc++;
            #1;
            if (done) got = 1;
        end
        rk_req    = 1'b0;
        key_valid = 1'b0;
        $display("expansion done after %0d cycles", cyc);
        check("done_latency", 128'(cyc), 128'd10);
        check("keys_valid_done", 128'(keys_valid), 128'd1);
        check("busy_done", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        check("done_pulse", 128'(done), 128'd0);
        check("keys_valid_hold", 128'(keys_valid), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key       = '0;
        rk_req    = 1'b0;
        rk_idx    = 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        build_sbox();
        #3;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_keys_valid", 128'(keys_valid), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_rk_data", rk_data, 128'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("key_ready_idle", 128'(key_ready), 128'd1);

        // Reads in IDLE are never valid.
        rd(4'd0, 1'b0, 128'h0);
        rd(4'd5, 1'b0, 128'h0);

        // FIPS vector, key_valid held through EXPAND, on-the-fly reads of rk[3].
        model_expand(FIPS_KEY);
        start_key(FIPS_KEY);
        wait_done(FIPS_KEY, 1'b1, 1'b1);

        for (int i = 0; i <= 10; i++) tbl[i] = '{4'(i), 1'b1, sched[i]};
        tbl[1].d  = FIPS_RK1;
        tbl[10].d = FIPS_RK10;
        tbl[11]   = '{4'd11, 1'b0, 128'h0};
        tbl[12]   = '{4'd15, 1'b0, 128'h0};
        for (int i = 0; i < 13; i++) rd(tbl[i].idx, tbl[i].v, tbl[i].d);

        // Reload an all-zero key from DONE.
        model_expand(128'h0);
        start_key(128'h0);
        wait_done(128'h0, 1'b0, 1'b0);
        rd(4'd10, 1'b1, ZERO_RK10);
        rd(4'd0, 1'b1, 128'h0);
        rd(4'd4, 1'b1, sched[4]);
        rd(4'd11, 1'b0, 128'h0);

        // Reset in the middle of an expansion.
        model_expand(FIPS_KEY);
        start_key(FIPS_KEY);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_keys_valid", 128'(keys_valid), 128'd0);
        check("midrst_rk_valid", 128'(rk_valid), 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_key_ready", 128'(key_ready), 128'd1);
        rd(4'd0, 1'b0, 128'h0);

        start_key(FIPS_KEY);
        wait_done(FIPS_KEY, 1'b0, 1'b0);
        rd(4'd10, 1'b1, FIPS_RK10);

`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b1;
        @(posedge clk);
        #1;
        zeroize = 1'b0;
        $display("zeroize pulsed");
        check("zeroize_keys_valid", 128'(keys_valid), 128'd0);
        check("zeroize_rk_valid", 128'(rk_valid), 128'd0);
        check("zeroize_key_ready", 128'(key_ready), 128'd1);
        rd(4'd0, 1'b0, 128'h0);
        start_key(FIPS_KEY);
        wait_done(FIPS_KEY, 1'b0, 1'b0);
        rd(4'd1, 1'b1, FIPS_RK1);
        rd(4'd10, 1'b1, FIPS_RK10);
`endif

        @(posedge clk);
        #1;
        check("sb_drained", 128'(sbq.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative, sequenced AES-128 round-key generator and round-key server for the cipher datapath. Accepts a 128-bit cipher key through a valid/ready handshake, then computes one 128-bit round key per clock using a single shared RotWord/SubWord/Rcon stage instead of 40 unrolled word stages. Stores all 11 round keys and serves them by round index with one-cycle read latency. It sits between the key source and the round datapath, and lets encryption start before expansion finishes.

## Interface
- `NUM_ROUNDS`, 10: number of rounds; round keys are indexed 0..`NUM_ROUNDS`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; all registers clear immediately.
- `key_valid` in 1: the cipher key on `key` is offered.
- `key_ready` out 1: the block can accept a key; high in IDLE and DONE.
- `key` in [0:127]: cipher key; bit 0 is the MSB of byte 0, which is w0 byte 0.
- `busy` out 1: high in EXPAND.
- `keys_valid` out 1: all 11 round keys are stored and stable.
- `done` out 1: one-cycle pulse when the last round key is written.
- `rk_req` in 1: round-key read request.
- `rk_idx` in 4: requested round index.
- `rk_valid` out 1: `rk_data` is valid; registered, one cycle after `rk_req`.
- `rk_data` out [0:127]: requested round key; 0 when `rk_valid` is 0.

## Operation
- States: IDLE, EXPAND, DONE.
- Key acceptance: a key is accepted when `key_valid` and `key_ready` are both high. The key is written to `rk[0]`, `round` is set to 1, `rcon` is set to 8'h01, and the state moves to EXPAND. A `key_valid` in EXPAND is ignored and not accepted.
- EXPAND cycle: `rk[round]` is computed from `rk[round-1]` = {p0,p1,p2,p3}:
  - t = SubWord(RotWord(p3)) ^ {rcon,24'h0}
  - w0 = p0^t, w1 = p1^w0, w2 = p2^w1, w3 = p3^w2
  - Then `round` increments and `rcon` takes xtime(rcon): shift left by one; if the MSB was 1, XOR with 8'h1B. The sequence is 01,02,04,08,10,20,40,80,1B,36.
- Last round: when `round`==`NUM_ROUNDS` is written, the state moves to DONE, `done` pulses, and `keys_valid` rises.
- Reload from DONE: a new key is accepted and the state returns to EXPAND. `keys_valid` falls on that same edge, and entries 1..10 are overwritten progressively.
- Read path:
  - A request is valid when `rk_idx` ≤ the highest written index (`round`-1 in EXPAND, 10 in DONE) and the state is not IDLE.
  - A valid request gives `rk_valid`=1 and `rk_data`=`rk[rk_idx]` on the next cycle.
  - An invalid request, or `rk_idx` > 10, gives `rk_valid`=0 and `rk_data`=0.
- Read/write collision: if the same cycle writes `rk[i]` and requests `rk_idx`=i, the read is invalid (not yet written); the requester retries.
- Reset values: state IDLE, `round` 0, `rcon` 8'h01, all `rk` entries 0, `busy` 0, `keys_valid` 0, `done` 0, `rk_valid` 0, `rk_data` 0, `key_ready` 1 once reset deasserts.
- Reset mid-EXPAND: the state returns to IDLE and all stored keys are lost.

## Timing
- Key accepted at edge E0 → `rk[1]` written at E1 → … → `rk[10]` written at E10.
- `done` and `keys_valid` are high after E10; `busy` is high from E0 to E10.
- Expansion latency is 10 cycles; the throughput limit is one new key per 11 cycles.
- Read latency is 1 cycle. Back-to-back `rk_req` gives back-to-back data.
- Critical path, per cycle: S-box, then a 4-XOR chain to w3. The S-box is a combinational ROM.

## Configuration
- `AES_KEY_ZEROIZE_EN`:
  - When defined, an input `zeroize` (1 bit) is added.
  - Asserting `zeroize` clears all `rk` entries to 0 on the next edge and forces IDLE, `keys_valid` 0, and `rk_valid` 0.
  - `zeroize` has priority over key acceptance and the read path.
  - When not defined, the port is absent and key material persists until overwritten or reset.

## Structure
- Package `aes_pkg`:
  - the state enum
  - `NUM_ROUNDS`=10 and `NK`=4
  - `RCON_INIT`=8'h01
  - an `xtime` function
  - the S-box constant array
- One sub-module, `aes_sub_word`: four byte S-box lookups on a 32-bit word, purely combinational, instantiated once.

## Test plan
- FIPS-197 vector:
  - Stimulus: `key`=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: `rk[1]`=a0fafe1788542cb123a339392a6c7605; `rk[10]`=d014f9a8c9ee2589e13f0cc8b6630ca6; `done` pulses exactly 10 cycles after acceptance.
- On-the-fly read:
  - Stimulus: request `rk_idx`=3 three cycles after acceptance, then again five cycles after acceptance.
  - Required: first request gives `rk_valid`=0, `rk_data`=0; second gives `rk_valid`=1 with the correct `rk[3]`.
- Handshake:
  - Stimulus: hold `key_valid` during EXPAND.
  - Required: `key_ready`=0 and no re-accept. In DONE, a new all-zero key is accepted and `rk[10]`=b4ef5bcb3e92e21123e951cf6f8f188e.
- Out-of-range read:
  - Stimulus: `rk_idx`=11 and `rk_idx`=15 in DONE; any read in IDLE.
  - Required: `rk_valid`=0 and `rk_data`=0 in every case.
- Reset mid-EXPAND:
  - Stimulus: assert `reset` at cycle 5.
  - Required: outputs go to reset values immediately; a subsequent read of index 0 gives `rk_valid`=0.
- Zeroize, with `AES_KEY_ZEROIZE_EN` defined:
  - Stimulus: pulse `zeroize` in DONE.
  - Required: `keys_valid`=0; after reloading, the FIPS vector result is correct.
